// File: rtl/resadd_pkg.sv
// resadd_pkg: shared definitions for the residual-add element-wise pipe.
//   op_t     - operation encodings carried on op_mode
//   state_t  - job controller state encoding
//   full_w() - width of the exact intermediate result
//              (main lane + shortcut lane + largest possible left shift)
package resadd_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,  // main minus shortcut
    OP_BYP = 2'd3   // main path only
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int full_w(input int in_dw, input int res_dw, input int scale_w);
    return in_dw + res_dw + (1 << scale_w);
  endfunction

  // Full width for the default lane geometry (32-bit main, 8-bit shortcut, 5-bit scales).
  localparam int FULL_W_DFLT = full_w(32, 8, 5);

endpackage

// File: rtl/resadd_lane.sv
// resadd_lane: one element lane, three register stages, all gated by adv.
//   stage 1: a = round_half_up(s0 >>> main_scale), b = sext(s1) << res_scale
//   stage 2: r = a op b at full width (cannot overflow)
//   stage 3: res = sat(relu(round_half_up(r >>> out_shift)))
// Ports: clk, rst_n (sync, active-low), adv (pipe advance), latched config
//   (op_mode, main_scale, res_scale, out_shift, relu_en), s0/s1 lane inputs,
//   res lane output (stage-3 register).
// Optional (RESADD_SAT_STAT_EN): clip - stage-2 contents will saturate when
//   they move into stage 3 this cycle.
module resadd_lane
  import resadd_pkg::*;
#(
  parameter int IN_DW   = 32,
  parameter int RES_DW  = 8,
  parameter int OUT_DW  = 8,
  parameter int SCALE_W = 5,
  parameter int FULL_W  = FULL_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  logic [1:0]         op_mode,
  input  logic [SCALE_W-1:0] main_scale,
  input  logic [SCALE_W-1:0] res_scale,
  input  logic [SCALE_W-1:0] out_shift,
  input  logic               relu_en,
  input  logic [IN_DW-1:0]   s0,
  input  logic [RES_DW-1:0]  s1,
`ifdef RESADD_SAT_STAT_EN
  output logic               clip,
`endif
  output logic [OUT_DW-1:0]  res
);

  // Signed output limits expressed at stage-3 working width.
  localparam logic signed [FULL_W:0] OUT_MAX = {{(FULL_W-OUT_DW+2){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [FULL_W:0] OUT_MIN = {{(FULL_W-OUT_DW+2){1'b1}}, {(OUT_DW-1){1'b0}}};

  // Stage 1. One guard bit so adding the rounding constant cannot wrap.
  logic signed [IN_DW:0]    s0_ext, rnd1, a_next, a_reg;
  logic [IN_DW:0]           one1;
  logic signed [FULL_W-1:0] b_next, b_reg;

  always_comb begin
    s0_ext = {s0[IN_DW-1], s0};
    one1   = (IN_DW+1)'(1) << main_scale;
    rnd1   = $signed(one1 >> 1);            // zero when main_scale == 0
    a_next = (s0_ext + rnd1) >>> main_scale;
    b_next = FULL_W'($signed(s1)) <<< res_scale;
  end

  // Stage 2.
  logic signed [FULL_W-1:0] a_full, r_next, r_reg;

  always_comb begin
    a_full = FULL_W'(a_reg);
    case (op_t'(op_mode))
      OP_ADD:  r_next = a_full + b_reg;
      OP_MUL:  r_next = a_full * b_reg;
      OP_SUB:  r_next = a_full - b_reg;
      default: r_next = a_full;
    endcase
  end

  // Stage 3.
  logic signed [FULL_W:0] r_ext, rnd3, q;
  logic [FULL_W:0]        one3;
  logic                   hi, lo;
  logic [OUT_DW-1:0]      y_next, y_reg;

  always_comb begin
    r_ext = {r_reg[FULL_W-1], r_reg};
    one3  = (FULL_W+1)'(1) << out_shift;
    rnd3  = $signed(one3 >> 1);
    q     = (r_ext + rnd3) >>> out_shift;
    if (relu_en && q[FULL_W]) begin
      q = '0;
    end
    hi     = q > OUT_MAX;
    lo     = q < OUT_MIN;
    y_next = hi ? OUT_MAX[OUT_DW-1:0] : (lo ? OUT_MIN[OUT_DW-1:0] : q[OUT_DW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      y_reg <= '0;
    end else if (adv) begin
      a_reg <= a_next;
      b_reg <= b_next;
      r_reg <= r_next;
      y_reg <= y_next;
    end
  end

  assign res = y_reg;
`ifdef RESADD_SAT_STAT_EN
  assign clip = hi | lo;
`endif

endmodule

// File: rtl/resadd_ew_pipe.sv
// resadd_ew_pipe: job-controlled residual add/mul/sub element-wise pipe.
// Joins a main-path stream (s0, IN_DW per lane) with a shortcut stream
// (s1, RES_DW per lane), runs LANES resadd_lane instances in a 3-stage pipe
// and emits OUT_DW-per-lane results on out_*. A job is launched by start in
// IDLE (config latched), accepts total_beats beats, drains, pulses done.
// Ports: clk, rst_n (sync, active-low), start, total_beats, op_mode,
//   main_scale, res_scale, out_shift, relu_en, s0_vld/s0_pd/s0_rdy,
//   s1_vld/s1_pd/s1_rdy, out_vld/out_pd/out_rdy, busy, done.
// Optional macro RESADD_SAT_STAT_EN adds sat_cnt[31:0]: lanes saturated over
//   the current job, cleared at start, sticks at all-ones.
module resadd_ew_pipe
  import resadd_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int IN_DW   = 32,
  parameter int RES_DW  = 8,
  parameter int OUT_DW  = 8,
  parameter int SCALE_W = 5,
  parameter int CNT_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        total_beats,
  input  logic [1:0]              op_mode,
  input  logic [SCALE_W-1:0]      main_scale,
  input  logic [SCALE_W-1:0]      res_scale,
  input  logic [SCALE_W-1:0]      out_shift,
  input  logic                    relu_en,
  input  logic                    s0_vld,
  input  logic [LANES*IN_DW-1:0]  s0_pd,
  output logic                    s0_rdy,
  input  logic                    s1_vld,
  input  logic [LANES*RES_DW-1:0] s1_pd,
  output logic                    s1_rdy,
  output logic                    out_vld,
  output logic [LANES*OUT_DW-1:0] out_pd,
  input  logic                    out_rdy,
`ifdef RESADD_SAT_STAT_EN
  output logic [31:0]             sat_cnt,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int FULL_W = full_w(IN_DW, RES_DW, SCALE_W);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, total_reg;
  logic [1:0]         mode_reg;
  logic [SCALE_W-1:0] ms_reg, rs_reg, os_reg;
  logic               relu_reg;
  logic               v1_reg, v2_reg, v3_reg;
  logic               adv, accept, last_beat, pipe_empty, launch;

  // The whole pipe moves together; it only freezes when the output slot is
  // occupied and not being taken.
  assign adv        = !v3_reg || out_rdy;
  assign accept     = (state_reg == ST_RUN) && s0_vld && s1_vld && adv;
  assign last_beat  = accept && ((cnt_reg + CNT_W'(1)) == total_reg);
  assign pipe_empty = !(v1_reg || v2_reg || v3_reg);
  assign launch     = (state_reg == ST_IDLE) && start;

  assign s0_rdy  = accept;
  assign s1_rdy  = accept;
  assign out_vld = v3_reg;

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (total_beats == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // No new beats can enter, so an empty pipe means the last output
        // handshaked on the previous edge.
        if (pipe_empty) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      total_reg <= '0;
      mode_reg  <= '0;
      ms_reg    <= '0;
      rs_reg    <= '0;
      os_reg    <= '0;
      relu_reg  <= 1'b0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        cnt_reg   <= '0;
        total_reg <= total_beats;
        mode_reg  <= op_mode;
        ms_reg    <= main_scale;
        rs_reg    <= res_scale;
        os_reg    <= out_shift;
        relu_reg  <= relu_en;
      end else if (accept) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (adv) begin
        v1_reg <= accept;
        v2_reg <= v1_reg;
        v3_reg <= v2_reg;
      end
    end
  end

`ifdef RESADD_SAT_STAT_EN
  logic [LANES-1:0] clip;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      resadd_lane #(
        .IN_DW  (IN_DW),
        .RES_DW (RES_DW),
        .OUT_DW (OUT_DW),
        .SCALE_W(SCALE_W),
        .FULL_W (FULL_W)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .op_mode   (mode_reg),
        .main_scale(ms_reg),
        .res_scale (rs_reg),
        .out_shift (os_reg),
        .relu_en   (relu_reg),
        .s0        (s0_pd[gi*IN_DW +: IN_DW]),
        .s1        (s1_pd[gi*RES_DW +: RES_DW]),
`ifdef RESADD_SAT_STAT_EN
        .clip      (clip[gi]),
`endif
        .res       (out_pd[gi*OUT_DW +: OUT_DW])
      );
    end
  endgenerate

`ifdef RESADD_SAT_STAT_EN
  localparam int NC_W = $clog2(LANES + 1);

  logic [NC_W-1:0] nclip;
  logic [32:0]     sat_sum;
  logic [31:0]     sat_reg;

  always_comb begin
    nclip = '0;
    for (int i = 0; i < LANES; i++) begin
      nclip = nclip + NC_W'(clip[i]);
    end
    sat_sum = {1'b0, sat_reg} + 33'(nclip);
  end

  // Clip flags describe stage 2, so they are counted as a valid beat moves
  // into stage 3.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_reg <= '0;
    end else if (launch) begin
      sat_reg <= '0;
    end else if (adv && v2_reg) begin
      sat_reg <= sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

  assign sat_cnt = sat_reg;
`endif

endmodule

// File: doc/resadd_ew_pipe.md
RESADD_EW_PIPE -- requirements
Module: resadd_ew_pipe

Interface
REQ-001 Parameter LANES, default 8, number of parallel element lanes per beat.
REQ-002 Parameter IN_DW, default 32, signed width of one main-path (conv) lane.
REQ-003 Parameter RES_DW, default 8, signed width of one shortcut lane.
REQ-004 Parameter OUT_DW, default 8, signed width of one output lane.
REQ-005 Parameter SCALE_W, default 5, width of every scale/shift field.
REQ-006 Parameter CNT_W, default 24, width of the beat counter.
REQ-007 Ports SHALL be as listed below.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle job launch pulse.
- total_beats  in  CNT_W  beats in the job.
- op_mode  in  2  0 add, 1 mul, 2 sub (main minus shortcut), 3 main bypass.
- main_scale  in  SCALE_W  main-path right shift.
- res_scale  in  SCALE_W  shortcut left shift.
- out_shift  in  SCALE_W  result right shift.
- relu_en  in  1  clamp negative results to 0.
- s0_vld / s0_pd / s0_rdy  in / in LANES*IN_DW / out  main-path stream.
- s1_vld / s1_pd / s1_rdy  in / in LANES*RES_DW / out  shortcut stream.
- out_vld / out_pd / out_rdy  out / out LANES*OUT_DW / in  result stream.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle job completion pulse.

Function
REQ-008 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start, latching all config inputs; start outside IDLE SHALL be ignored.
REQ-009 start with total_beats=0 SHALL go IDLE->DRAIN and pulse done the cycle after DRAIN is entered, producing no output.
REQ-010 Join: one beat accepted when state=RUN, s0_vld=1, s1_vld=1 and the pipe advances; s0_rdy=s1_rdy=exactly that condition, so neither stream is consumed alone.
REQ-011 Pipe SHALL advance when stage-3 slot empty or out_rdy=1; when stalled, all stages and out_pd SHALL hold.
REQ-012 Latency SHALL be 3 cycles from accept to out_vld with no backpressure; full throughput of one beat per cycle.
REQ-013 Stage 1: a = s0 lane arithmetic-right-shifted by main_scale, round-half-up; b = sign-extended s1 lane left-shifted by res_scale.
REQ-014 Stage 2: r = a+b, a*b, a-b or a per op_mode, computed at full width (IN_DW+RES_DW+2^SCALE_W bits) without overflow.
REQ-015 Stage 3: r arithmetic-right-shifted by out_shift, round-half-up; relu if enabled; saturated to signed OUT_DW range.
REQ-016 Accepted-beat counter cleared at start; when it reaches total_beats, RUN->DRAIN and rdy SHALL deassert.
REQ-017 DRAIN->IDLE with done=1 the cycle after the last output beat handshakes; busy drops with done.

Reset
REQ-018 With rst_n=0 at a clock edge: state=IDLE, counters 0, all stage valids 0, out_vld=0, out_pd=0, s0_rdy=s1_rdy=0, busy=0, done=0.
REQ-019 Reset mid-job SHALL discard in-flight beats with no done pulse.

Configuration
REQ-020 Macro RESADD_SAT_STAT_EN defined: output port sat_cnt[31:0] counts lanes clipped in REQ-015 over the job, cleared at start, saturating at all-ones; undefined: port and logic absent, behaviour otherwise identical.

Structure
REQ-021 Package resadd_pkg SHALL hold op_mode encodings, FSM state encoding and the full-width constant.
REQ-022 Per-lane arithmetic of REQ-013..015 SHALL live in sub-module resadd_lane, instantiated LANES times.

Verification
REQ-023 LANES=8, add, scales 0, s0 lane=100, s1 lane=27, total_beats=4 -> four outputs of 127, done one cycle after 4th handshake.
REQ-024 add, s0=200, s1=100 -> 127 (saturate); relu_en=1, sub, s0=5, s1=9 -> 0; sat_cnt=8 per saturated beat when RESADD_SAT_STAT_EN defined.
REQ-025 mul, main_scale=2, s0=13 (a=3 after rounding), s1=-4, out_shift=1 -> -6.
REQ-026 s1_vld held low 5 cycles while s0_vld=1 -> s0_rdy stays 0, no beat consumed; out_rdy low 3 cycles mid-stream -> outputs held, no loss or duplication.
REQ-027 total_beats=0 -> done pulses, no out_vld; rst_n low mid-job -> IDLE, no done, next job runs correctly.
